// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: flow-controlled pipeline boundary register with a
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   flush          synchronous squash of all held entries
//   in_valid/in_ready/in_data     upstream valid/ready handshake
//   out_valid/out_ready/out_data  downstream valid/ready handshake
//   occupancy      number of held entries (0..2)
//   stall_count    saturating count of out_valid & !out_ready cycles
//   stall_clr      synchronous clear of stall_count
module pipe_stage_elastic #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count,
  input  logic              stall_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] skid_q;
  logic              xfer_in;
  logic              xfer_out;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;
  logic [1:0]        occ_d;

  // in_ready and out_valid are flops, so neither handshake has a comb path.
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // Next-state and data-load decode.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    occ_d          = 2'd0;
    case (state_q)
      S_EMPTY: begin
        if (xfer_in) begin
          main_load = 1'b1;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (xfer_in && xfer_out) begin
          main_load = 1'b1;
        end else if (xfer_in) begin
          skid_load = 1'b1;
          state_d   = S_FULL;
        end else if (xfer_out) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (xfer_out) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush discards any accepted input; an outgoing transfer already happened.
    if (flush) begin
      state_d        = S_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
    case (state_d)
      S_ONE:   occ_d = 2'd1;
      S_FULL:  occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // State and decoded handshake/occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != S_EMPTY);
      in_ready  <= (state_d != S_FULL);
      occupancy <= occ_d;
    end
  end

  // Payload registers; cleared on reset/flush only when CLEAR_DATA is set.
  always_ff @(posedge clk) begin
    if (CLEAR_DATA && (reset || flush)) begin
      out_data <= '0;
      skid_q   <= '0;
    end else if (!reset) begin
      if (main_load) begin
        out_data <= main_from_skid ? skid_q : in_data;
      end
      if (skid_load) begin
        skid_q <= in_data;
      end
    end
  end

  // Saturating stall counter; clear beats increment, flush does not touch it.
  always_ff @(posedge clk) begin
    if (reset || stall_clr) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed vector table, hand-written stall/reset
// sequences and a randomised scoreboard run for pipe_stage_elastic.
module tb_pipe_stage_elastic;

  localparam int unsigned DW = 73;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_count;
  logic          stall_clr;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_elastic #(.DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_count(stall_count),
    .stall_clr  (stall_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [1:0]    e_occ;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic fl,
                              logic e_ov, logic [DW-1:0] e_od, logic e_ir, logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, clock once, then sample 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic fl, input logic clr, input logic rst);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_word;
  logic [DW-1:0] prev_data;
  logic          prev_stall;
  logic          hold_in;

  initial begin
    // Directed vectors: expected outputs are those seen right after the edge.
    vecs[0]  = mk(1, 73'h11, 1, 0, 1, 73'h11, 1, 1);
    vecs[1]  = mk(1, 73'h22, 1, 0, 1, 73'h22, 1, 1);
    vecs[2]  = mk(1, 73'h33, 1, 0, 1, 73'h33, 1, 1);
    vecs[3]  = mk(0, 73'h0,  1, 0, 0, 73'h33, 1, 0);
    vecs[4]  = mk(1, 73'hA0, 1, 0, 1, 73'hA0, 1, 1);
    vecs[5]  = mk(1, 73'hA1, 0, 0, 1, 73'hA0, 0, 2);
    vecs[6]  = mk(1, 73'hA1, 1, 0, 1, 73'hA1, 1, 1);
    vecs[7]  = mk(0, 73'h0,  1, 0, 0, 73'hA1, 1, 0);
    vecs[8]  = mk(1, 73'hB0, 0, 0, 1, 73'hB0, 1, 1);
    vecs[9]  = mk(1, 73'hB1, 0, 0, 1, 73'hB0, 0, 2);
    vecs[10] = mk(1, 73'hB2, 0, 1, 0, 73'h0,  1, 0);
    vecs[11] = mk(0, 73'h0,  1, 0, 0, 73'h0,  1, 0);
    vecs[12] = mk(1, 73'hC0, 1, 0, 1, 73'hC0, 1, 1);
    vecs[13] = mk(1, 73'hC1, 1, 1, 0, 73'h0,  1, 0);
    vecs[14] = mk(0, 73'h0,  1, 0, 0, 73'h0,  1, 0);

    in_valid = 0; in_data = '0; out_ready = 0; flush = 0; stall_clr = 0; reset = 1;
    repeat (3) @(posedge clk);
    #1;
    cyc(0, '0, 0, 0, 0, 0);
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset occupancy", 128'(occupancy), 128'(0));
    chk("reset stall_count", 128'(stall_count), 128'(0));
    chk("reset out_data", 128'(out_data), 128'(0));

    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, 0, 0);
      chk($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].e_ov));
      chk($sformatf("vec%0d out_data", i),  128'(out_data),  128'(vecs[i].e_od));
      chk($sformatf("vec%0d in_ready", i),  128'(in_ready),  128'(vecs[i].e_ir));
      chk($sformatf("vec%0d occupancy", i), 128'(occupancy), 128'(vecs[i].e_occ));
    end

    // Stall counter saturation and clear-over-increment.
    cyc(0, '0, 1, 0, 1, 0);
    chk("stall cleared", 128'(stall_count), 128'(0));
    cyc(1, 73'hD0, 0, 0, 0, 0);
    chk("stall none while empty", 128'(stall_count), 128'(0));
    for (int k = 1; k <= 10; k++) begin
      cyc(0, '0, 0, 0, 0, 0);
      chk($sformatf("stall cnt k=%0d", k), 128'(stall_count), 128'((k > 7) ? 7 : k));
      chk($sformatf("stall data k=%0d", k), 128'(out_data), 128'(73'hD0));
    end
    cyc(0, '0, 0, 0, 1, 0);
    chk("stall_clr wins", 128'(stall_count), 128'(0));
    cyc(0, '0, 0, 0, 0, 0);
    chk("stall after clr", 128'(stall_count), 128'(1));

    // Build FULL with stall_count=5, then reset.
    cyc(1, 73'hD1, 0, 0, 0, 0);
    chk("pre-reset occupancy", 128'(occupancy), 128'(2));
    repeat (3) cyc(1, 73'hD1, 0, 0, 0, 0);
    chk("pre-reset stall", 128'(stall_count), 128'(5));
    cyc(1, 73'hD1, 0, 0, 0, 1);
    chk("post-reset out_valid", 128'(out_valid), 128'(0));
    chk("post-reset in_ready", 128'(in_ready), 128'(1));
    chk("post-reset occupancy", 128'(occupancy), 128'(0));
    chk("post-reset stall", 128'(stall_count), 128'(0));
    chk("post-reset out_data", 128'(out_data), 128'(0));

    // Random traffic against a FIFO scoreboard.
    in_valid = 0; out_ready = 0; reset = 0; flush = 0; stall_clr = 0;
    prev_stall = 0; prev_data = '0; hold_in = 0;
    for (int c = 0; c < 12000; c++) begin
      if (prev_stall) chk("stall stability", 128'(out_data), 128'(prev_data));
      chk("rand occupancy", 128'(occupancy), 128'(sb.size()));
      if (!hold_in) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data  = DW'({$urandom(), $urandom(), $urandom()});
      end
      out_ready = ($urandom_range(0, 99) < 55);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rand unexpected output", 128'(1), 128'(0));
        end else begin
          exp_word = sb.pop_front();
          chk("rand out_data", 128'(out_data), 128'(exp_word));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      hold_in    = in_valid && !in_ready;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk);
      #1;
    end

    // Drain and confirm nothing was lost.
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("drain unexpected output", 128'(1), 128'(0));
        end else begin
          exp_word = sb.pop_front();
          chk("drain out_data", 128'(out_data), 128'(exp_word));
        end
      end
      @(posedge clk);
      #1;
    end
    chk("drain scoreboard empty", 128'(sb.size()), 128'(0));
    chk("drain out_valid", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
